codec_slave: RTL and testbench
==============================

Name: codec_slave

Overview:
- Synthesizable model of the codec end of the I2S-style audio link: LRCLK, SCLK and RSTn are inputs, SDin is received, SDout is driven.
- Deserializes left/right samples from SDin and presents them as a parallel pair with a one-cycle valid strobe.
- Serializes a buffered left/right pair onto SDout.
- Serves as the far end for digitizer-core loopback tests and as a board-level codec stand-in on FPGA.

Parameters:
- DATA_W, 16, sample width in bits; also the number of SCLK bits per LRCLK half.
- SYNC_STAGES, 2, flops in each input synchronizer for LRCLK, SCLK, RSTn and SDin.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- LRCLK  in  1  frame clock; high = left slot, low = right slot
- SCLK  in  1  bit clock
- RSTn  in  1  codec reset from master; low holds the block idle
- SDin  in  1  serial data from master, MSB first
- SDout  out  1  serial data to master, MSB first
- rx_lft  out  DATA_W  last received left sample
- rx_rht  out  DATA_W  last received right sample
- rx_valid  out  1  one-clk pulse when rx_lft/rx_rht update
- tx_lft  in  DATA_W  left sample to send
- tx_rht  in  DATA_W  right sample to send
- tx_wr  in  1  write tx_lft/tx_rht into the holding buffer
- tx_full  out  1  holding buffer occupied
- tx_underrun  out  1  sticky: a frame started with the buffer empty
- err_cnt  out  8  frame error count (present only with FRAME_ERR_CNT_EN)

Behaviour:
- Reset values: all outputs 0, buffer empty, state WAIT_RST.
- Synchronization and edge detection:
  - All four serial-side inputs pass through SYNC_STAGES flops.
  - Edges are detected on the synchronized values using a one-flop delay.
  - LRCLK edges coincide with SCLK falling edges.
- State machine, four states:
  - WAIT_RST: SDout=0. Go to SYNC when synchronized RSTn=1.
  - SYNC: wait for the first LRCLK rising edge, then go to LEFT. A falling edge is ignored here.
  - LEFT: go to RIGHT on an LRCLK falling edge.
  - RIGHT: go to LEFT on an LRCLK rising edge.
  - From any state, synchronized RSTn=0 forces WAIT_RST within one clk. Rx/tx shift registers and the bit counter are cleared; rx_lft/rx_rht and the holding buffer are retained.
- Receive path:
  - In LEFT/RIGHT, shift SDin into the rx shift register on each SCLK rising edge while bit_cnt < DATA_W.
  - bit_cnt resets to 0 on every LRCLK edge. Extra SCLK rising edges beyond DATA_W are ignored.
  - On the DATA_W-th left bit, latch the left word internally.
  - On the DATA_W-th right bit, update rx_lft (latched left word) and rx_rht together. Pulse rx_valid on the following clk.
- Transmit path:
  - On an LRCLK rising edge (entering LEFT), if the buffer is full, load tx shift ← buffered left, stage right ← buffered right, and clear tx_full.
  - If the buffer is empty, load 0 for both and set tx_underrun (sticky until rst_n).
  - On an LRCLK falling edge, load tx shift ← staged right.
  - On each SCLK falling edge that is not an LRCLK edge, shift left, filling with 0.
  - SDout = tx shift MSB, registered.
- Buffer:
  - tx_wr while tx_full=0: capture the pair and set tx_full next clk.
  - tx_wr while tx_full=1: ignored (no overwrite).
  - tx_wr in the same clk as a frame-start unload: the buffer is unloaded first, then the new pair is captured; tx_full stays 1.

Optional Feature:
- Macro FRAME_ERR_CNT_EN.
- Defined:
  - At each LRCLK edge in LEFT/RIGHT, if fewer than DATA_W SCLK rising edges occurred in the completed half, increment err_cnt, saturating at 255.
  - The err_cnt port exists.
- Undefined: no counter and no err_cnt port; a short half leaves partial data and rx_valid is not pulsed for that frame.

Decomposition:
- Package codec_pkg holds:
  - the state enum typedef (WAIT_RST, SYNC, LEFT, RIGHT);
  - the DATA_W default;
  - the LRCLK/SCLK divide constants (1024, 32) shared with the master-side interface.
- One sub-module, codec_sync_edge: a SYNC_STAGES synchronizer plus rise/fall detect, instantiated for LRCLK, SCLK and RSTn.

Test Plan:
- Reset, RSTn low, then RSTn high mid-left-slot → no rx_valid until one full LRCLK period after the first rising edge; SDout=0 throughout the first partial frame.
- tx_wr lft=16'hA5C3, rht=16'h0F0F before a frame → SDout carries A5C3 MSB-first over 16 SCLKs in the left slot and 0F0F in the right; tx_full drops at the LRCLK rising edge.
- Master drives left=16'h1234, right=16'hFEDC → rx_lft=1234, rx_rht=FEDC, one-clk rx_valid after the 16th right bit.
- No tx_wr before a frame → SDout all 0 and tx_underrun=1; a later tx_wr does not clear it.
- tx_wr while full, with a different pair → the original pair is transmitted; the second pair is dropped.
- FRAME_ERR_CNT_EN: truncate the left half to 10 SCLKs → err_cnt=1 and no rx_valid that frame; next good frame → rx_valid pulses and err_cnt stays 1.

Source files
------------

// File: rtl/codec_pkg.sv
// Shared definitions for the codec-side audio link: FSM states, default sample
// width and the LRCLK/SCLK divide ratios used by the master-side interface.
package codec_pkg;

    typedef enum logic [1:0] {
        WAIT_RST,
        SYNC,
        LEFT,
        RIGHT
    } codec_state_t;

    localparam int CODEC_DATA_W = 16;
    localparam int LRCLK_DIV    = 1024;
    localparam int SCLK_DIV     = 32;
    localparam int ERR_CNT_W    = 8;

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (v == {ERR_CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/codec_sync_edge.sv
// Multi-flop synchronizer for one slow serial-side input, with rise/fall
// detection against a one-flop delayed copy of the synchronized level.
module codec_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= (sync_q << 1) | SYNC_STAGES'(d);
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign q    = sync_q[SYNC_STAGES-1];
    assign rise = q & ~prev_q;
    assign fall = ~q & prev_q;

endmodule

// File: rtl/codec_slave.sv
// Codec end of an I2S-style link: deserializes SDin into left/right pairs and
// serializes a buffered pair onto SDout. Optional FRAME_ERR_CNT_EN adds err_cnt.
module codec_slave
    import codec_pkg::*;
#(
    parameter int DATA_W      = CODEC_DATA_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              LRCLK,
    input  logic              SCLK,
    input  logic              RSTn,
    input  logic              SDin,
    output logic              SDout,
    output logic [DATA_W-1:0] rx_lft,
    output logic [DATA_W-1:0] rx_rht,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_lft,
    input  logic [DATA_W-1:0] tx_rht,
    input  logic              tx_wr,
    output logic              tx_full,
    output logic              tx_underrun
`ifdef FRAME_ERR_CNT_EN
    ,
    output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

    localparam int                CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    codec_state_t state;

    logic lr_lvl, lr_rise, lr_fall;
    logic sclk_lvl, sclk_rise, sclk_fall;
    logic rstn_s, rstn_rise, rstn_fall;

    logic [SYNC_STAGES-1:0] sdin_sync;
    logic                   sdin_s;

    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] rx_shift;
    logic [DATA_W-1:0] rx_word;
    logic [DATA_W-1:0] lft_word;
    logic              lft_ok;
    logic [DATA_W-1:0] tx_shift;
    logic [DATA_W-1:0] tx_stage;
    logic [DATA_W-1:0] buf_lft;
    logic [DATA_W-1:0] buf_rht;

    logic in_frame;
    logic lr_edge;
    logic frame_start;
    logic bit_in;
    logic half_done;

    codec_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_lrclk (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (LRCLK),
        .q    (lr_lvl),
        .rise (lr_rise),
        .fall (lr_fall)
    );

    codec_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (SCLK),
        .q    (sclk_lvl),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    codec_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_rstn (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (RSTn),
        .q    (rstn_s),
        .rise (rstn_rise),
        .fall (rstn_fall)
    );

    // SDin gets the same depth as SCLK so the sampled bit lines up with the detected rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sdin_sync <= '0;
        end else begin
            sdin_sync <= (sdin_sync << 1) | SYNC_STAGES'(SDin);
        end
    end

    assign sdin_s = sdin_sync[SYNC_STAGES-1];

    logic unused_edges;
    assign unused_edges = &{1'b0, lr_lvl, sclk_lvl, rstn_rise, rstn_fall};

    assign in_frame    = (state == LEFT) || (state == RIGHT);
    assign lr_edge     = lr_rise || lr_fall;
    assign frame_start = rstn_s && lr_rise && ((state == SYNC) || (state == RIGHT));
    assign bit_in      = rstn_s && in_frame && sclk_rise && (bit_cnt < FULL_CNT);
    assign half_done   = bit_in && (bit_cnt == LAST_BIT);
    assign rx_word     = {rx_shift[DATA_W-2:0], sdin_s};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= WAIT_RST;
            bit_cnt     <= '0;
            rx_shift    <= '0;
            lft_word    <= '0;
            lft_ok      <= 1'b0;
            tx_shift    <= '0;
            tx_stage    <= '0;
            SDout       <= 1'b0;
            rx_lft      <= '0;
            rx_rht      <= '0;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            SDout    <= (state == WAIT_RST) ? 1'b0 : tx_shift[DATA_W-1];

            if (!rstn_s) begin
                state    <= WAIT_RST;
                bit_cnt  <= '0;
                rx_shift <= '0;
                lft_ok   <= 1'b0;
                tx_shift <= '0;
                tx_stage <= '0;
            end else begin
                case (state)
                    WAIT_RST: state <= SYNC;
                    SYNC:     if (lr_rise) state <= LEFT;
                    LEFT:     if (lr_fall) state <= RIGHT;
                    RIGHT:    if (lr_rise) state <= LEFT;
                    default:  state <= WAIT_RST;
                endcase

                if (lr_edge) begin
                    bit_cnt <= '0;
                end else if (bit_in) begin
                    bit_cnt  <= bit_cnt + 1'b1;
                    rx_shift <= rx_word;
                end

                // A pair is published only if the left half of the same frame was complete.
                if (frame_start) begin
                    lft_ok <= 1'b0;
                end else if (half_done && (state == LEFT)) begin
                    lft_word <= rx_word;
                    lft_ok   <= 1'b1;
                end else if (half_done && (state == RIGHT) && lft_ok) begin
                    rx_lft   <= lft_word;
                    rx_rht   <= rx_word;
                    rx_valid <= 1'b1;
                end

                if (frame_start) begin
                    if (tx_full) begin
                        tx_shift <= buf_lft;
                        tx_stage <= buf_rht;
                    end else begin
                        tx_shift    <= '0;
                        tx_stage    <= '0;
                        tx_underrun <= 1'b1;
                    end
                end else if (in_frame && lr_fall) begin
                    tx_shift <= tx_stage;
                end else if (in_frame && sclk_fall && !lr_edge) begin
                    tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
                end
            end
        end
    end

    // Unload at frame start takes priority, so a same-cycle write refills the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_full <= 1'b0;
        end else if (tx_wr && (!tx_full || frame_start)) begin
            tx_full <= 1'b1;
        end else if (frame_start) begin
            tx_full <= 1'b0;
        end
    end

    // NOTE: buffer data needs no reset; tx_full alone decides whether it is ever read.
    always_ff @(posedge clk) begin
        if (tx_wr && (!tx_full || frame_start)) begin
            buf_lft <= tx_lft;
            buf_rht <= tx_rht;
        end
    end

`ifdef FRAME_ERR_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (rstn_s && in_frame && lr_edge && (bit_cnt < FULL_CNT)) begin
            err_cnt <= sat_inc(err_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_codec_slave.sv
// Scoreboard bench for codec_slave: a bench-side master drives LRCLK/SCLK/SDin,
// expected rx pairs and SDout words are queued and checked by separate monitors.
module tb_codec_slave;
    import codec_pkg::*;

    localparam int DW = CODEC_DATA_W;

    logic          clk;
    logic          rst_n;
    logic          LRCLK;
    logic          SCLK;
    logic          RSTn;
    logic          SDin;
    logic          SDout;
    logic [DW-1:0] rx_lft;
    logic [DW-1:0] rx_rht;
    logic          rx_valid;
    logic [DW-1:0] tx_lft;
    logic [DW-1:0] tx_rht;
    logic          tx_wr;
    logic          tx_full;
    logic          tx_underrun;
`ifdef FRAME_ERR_CNT_EN
    logic [7:0]    err_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    logic [2*DW-1:0] rx_q[$];
    logic [DW-1:0]   tx_q[$];

    codec_slave dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .LRCLK      (LRCLK),
        .SCLK       (SCLK),
        .RSTn       (RSTn),
        .SDin       (SDin),
        .SDout      (SDout),
        .rx_lft     (rx_lft),
        .rx_rht     (rx_rht),
        .rx_valid   (rx_valid),
        .tx_lft     (tx_lft),
        .tx_rht     (tx_rht),
        .tx_wr      (tx_wr),
        .tx_full    (tx_full),
        .tx_underrun(tx_underrun)
`ifdef FRAME_ERR_CNT_EN
        ,
        .err_cnt    (err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tx_write(input logic [DW-1:0] l, input logic [DW-1:0] r);
        @(negedge clk);
        tx_lft = l;
        tx_rht = r;
        tx_wr  = 1'b1;
        @(negedge clk);
        tx_wr  = 1'b0;
    endtask

    // One LRCLK half: nbits SCLK periods of SCLK_DIV clk each, data changes on SCLK fall.
    task automatic drive_half(input logic lr, input logic [DW-1:0] word, input int nbits,
                              input int rstn_at, input logic [DW-1:0] tx_exp);
        if (nbits == DW) tx_q.push_back(tx_exp);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            if (i == 0) LRCLK = lr;
            if (i == rstn_at) RSTn = 1'b1;
            SCLK = 1'b0;
            SDin = word[DW-1-i];
            repeat (SCLK_DIV / 2 - 1) @(negedge clk);
            @(negedge clk);
            SCLK = 1'b1;
            repeat (SCLK_DIV / 2 - 1) @(negedge clk);
        end
    endtask

    // rx monitor: every rx_valid pops one expected pair; the pulse must last one clk.
    logic prev_valid = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (prev_valid) check("rx_valid_width", 32'(rx_valid), 32'd0);
            prev_valid = rx_valid;
            if (rx_valid === 1'b1) begin
                if (rx_q.size() == 0) begin
                    check("rx_unexpected_valid", 32'(rx_q.size()), 32'd1);
                end else begin
                    logic [2*DW-1:0] e;
                    e = rx_q.pop_front();
                    check("rx_lft", 32'(rx_lft), 32'(e[2*DW-1:DW]));
                    check("rx_rht", 32'(rx_rht), 32'(e[DW-1:0]));
                end
            end
        end
    end

    // tx monitor: the master samples SDout on SCLK rise, counting restarts on LRCLK edges.
    initial begin
        logic          last_lr;
        logic [DW-1:0] sh;
        int            cnt;
        last_lr = 1'b0;
        sh      = '0;
        cnt     = 0;
        forever begin
            @(posedge SCLK or LRCLK);
            if (LRCLK !== last_lr) begin
                last_lr = LRCLK;
                cnt     = 0;
            end else if (SCLK === 1'b1) begin
                sh = {sh[DW-2:0], SDout};
                cnt++;
                if (cnt == DW) begin
                    if (tx_q.size() == 0) begin
                        check("tx_unexpected_word", 32'(tx_q.size()), 32'd1);
                    end else begin
                        logic [DW-1:0] e;
                        e = tx_q.pop_front();
                        check("sdout_word", 32'(sh), 32'(e));
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n  = 1'b0;
        LRCLK  = 1'b0;
        SCLK   = 1'b0;
        RSTn   = 1'b0;
        SDin   = 1'b0;
        tx_lft = '0;
        tx_rht = '0;
        tx_wr  = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check("reset_sdout", 32'(SDout), 32'd0);
        check("reset_rx_valid", 32'(rx_valid), 32'd0);
        check("reset_rx_lft", 32'(rx_lft), 32'd0);
        check("reset_rx_rht", 32'(rx_rht), 32'd0);
        check("reset_tx_full", 32'(tx_full), 32'd0);
        check("reset_tx_underrun", 32'(tx_underrun), 32'd0);
`ifdef FRAME_ERR_CNT_EN
        check("reset_err_cnt", 32'(err_cnt), 32'd0);
`endif

        tx_write(16'hA5C3, 16'h0F0F);
        check("tx_full_after_wr", 32'(tx_full), 32'd1);

        // Whole frame with RSTn low, then RSTn released mid-left: SDout stays 0.
        drive_half(1'b1, 16'hDEAD, DW, -1, 16'h0000);
        drive_half(1'b0, 16'hBEEF, DW, -1, 16'h0000);
        drive_half(1'b1, 16'h1111, DW, 8, 16'h0000);
        drive_half(1'b0, 16'h2222, DW, -1, 16'h0000);
        check("tx_full_held_in_sync", 32'(tx_full), 32'd1);
        check("underrun_before_frame", 32'(tx_underrun), 32'd0);

        // Frame 1: first real frame.
        drive_half(1'b1, 16'h1234, DW, -1, 16'hA5C3);
        check("tx_full_unloaded_f1", 32'(tx_full), 32'd0);
        rx_q.push_back({16'h1234, 16'hFEDC});
        drive_half(1'b0, 16'hFEDC, DW, -1, 16'h0F0F);

        // Frame 2: second write while full is dropped.
        tx_write(16'h1111, 16'h2222);
        check("tx_full_f2_wr1", 32'(tx_full), 32'd1);
        tx_write(16'h3333, 16'h4444);
        check("tx_full_f2_wr2", 32'(tx_full), 32'd1);
        drive_half(1'b1, 16'h8001, DW, -1, 16'h1111);
        check("tx_full_unloaded_f2", 32'(tx_full), 32'd0);
        check("underrun_f2", 32'(tx_underrun), 32'd0);
        rx_q.push_back({16'h8001, 16'h7FFE});
        drive_half(1'b0, 16'h7FFE, DW, -1, 16'h2222);

        // Frame 3: empty buffer at frame start.
        drive_half(1'b1, 16'hA5A5, DW, -1, 16'h0000);
        check("underrun_f3", 32'(tx_underrun), 32'd1);
        rx_q.push_back({16'hA5A5, 16'h5A5A});
        drive_half(1'b0, 16'h5A5A, DW, -1, 16'h0000);
        tx_write(16'hABCD, 16'h1234);
        check("underrun_sticky", 32'(tx_underrun), 32'd1);
        check("tx_full_f4_wr", 32'(tx_full), 32'd1);

        // Frame 4: left half cut to 10 SCLKs, no rx pair for this frame.
        drive_half(1'b1, 16'hFFFF, 10, -1, 16'h0000);
        check("tx_full_unloaded_f4", 32'(tx_full), 32'd0);
        drive_half(1'b0, 16'h0001, DW, -1, 16'h1234);
`ifdef FRAME_ERR_CNT_EN
        check("err_cnt_short", 32'(err_cnt), 32'd1);
`endif

        // Frame 5: good frame after the short one.
        drive_half(1'b1, 16'hC001, DW, -1, 16'h0000);
        rx_q.push_back({16'hC001, 16'h00FF});
        drive_half(1'b0, 16'h00FF, DW, -1, 16'h0000);
        repeat (40) @(negedge clk);
`ifdef FRAME_ERR_CNT_EN
        check("err_cnt_good", 32'(err_cnt), 32'd1);
`endif
        check("rx_pairs_pending", 32'(rx_q.size()), 32'd0);
        check("tx_words_pending", 32'(tx_q.size()), 32'd0);
        check("rx_lft_final", 32'(rx_lft), 32'h0000C001);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
